// File: rtl/pong_pkg.sv
// Shared pong constants: screen geometry, default ball/paddle geometry,
// colours and the ball update FSM state encoding.
package pong_pkg;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;

  localparam int WALL_DEF      = 8;
  localparam int BALL_SIZE_DEF = 4;
  localparam int PADDLE_H_DEF  = 32;
  localparam int PADDLE_W_DEF  = 4;
  localparam int P1_X_DEF      = 8;
  localparam int P2_X_DEF      = 308;

  // Serve position used after reset and after every point
  localparam int START_X = 158;
  localparam int START_Y = 118;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] WHITE = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ERASE = 2'd1,
    MOVE  = 2'd2,
    DRAW  = 2'd3
  } ball_state_e;

endpackage

// File: rtl/ball_engine_if.sv
// Framebuffer write port towards vga_adapter.
interface ball_engine_if;
  logic [9:0] X;
  logic [8:0] Y;
  logic [2:0] color;
  logic       plot;

  modport master (output X, output Y, output color, output plot);
  modport slave  (input X, input Y, input color, input plot);
endinterface

// File: rtl/pixel_sweeper.sv
// SIZE x SIZE raster counter (column fastest). start clears the offsets,
// step advances one pixel, done flags the step that covers the last pixel.
module pixel_sweeper #(
  parameter int SIZE = 4,
  parameter int OW   = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          step,
  output logic [OW-1:0] x_off,
  output logic [OW-1:0] y_off,
  output logic          done
);

  localparam logic [OW-1:0] LAST = OW'(SIZE - 1);

  logic [OW-1:0] x_off_r;
  logic [OW-1:0] y_off_r;

  assign x_off = x_off_r;
  assign y_off = y_off_r;
  assign done  = step && (x_off_r == LAST) && (y_off_r == LAST);

  // Offset counters: clear on start, advance column-first on step
  always_ff @(posedge clk) begin
    if (rst || start) begin
      x_off_r <= {OW{1'b0}};
      y_off_r <= {OW{1'b0}};
    end else if (step) begin
      if (x_off_r == LAST) begin
        x_off_r <= {OW{1'b0}};
        y_off_r <= (y_off_r == LAST) ? {OW{1'b0}} : y_off_r + OW'(1);
      end else begin
        x_off_r <= x_off_r + OW'(1);
        y_off_r <= y_off_r;
      end
    end else begin
      x_off_r <= x_off_r;
      y_off_r <= y_off_r;
    end
  end

endmodule

// File: rtl/ball_engine.sv
// Pong ball engine: on each tick erases the ball, moves it one step with
// wall/paddle bounces and miss scoring, then redraws it.
module ball_engine #(
  parameter int BALL_SIZE = pong_pkg::BALL_SIZE_DEF,
  parameter int PADDLE_H  = pong_pkg::PADDLE_H_DEF,
  parameter int PADDLE_W  = pong_pkg::PADDLE_W_DEF,
  parameter int P1_X      = pong_pkg::P1_X_DEF,
  parameter int P2_X      = pong_pkg::P2_X_DEF,
  parameter int WALL      = pong_pkg::WALL_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tick,
  input  logic [8:0]     p1_y,
  input  logic [8:0]     p2_y,
  ball_engine_if.master  fb,
  output logic           busy,
  output logic           p1_point,
  output logic           p2_point
);
  import pong_pkg::*;

  localparam int OW = (BALL_SIZE > 1) ? $clog2(BALL_SIZE) : 1;

  localparam logic [9:0] BS10    = 10'(BALL_SIZE);
  localparam logic [8:0] BS9     = 9'(BALL_SIZE);
  localparam logic [8:0] PH9     = 9'(PADDLE_H);
  localparam logic [8:0] WALL9   = 9'(WALL);
  localparam logic [8:0] Y_LIM9  = 9'(SCREEN_H - WALL);
  localparam logic [9:0] SCR_W10 = 10'(SCREEN_W);
  localparam logic [9:0] P1_EDGE = 10'(P1_X + PADDLE_W);
  localparam logic [9:0] P2_EDGE = 10'(P2_X);
  localparam logic [9:0] SX10    = 10'(START_X);
  localparam logic [8:0] SY9     = 9'(START_Y);

  ball_state_e state_r, state_s;
  logic [9:0]  bx_r, nbx_s;
  logic [8:0]  by_r, nby_s;
  logic        dir_x_r, ndx_s;   // 1 = moving left
  logic        dir_y_r, ndy_s;   // 1 = moving up
  logic        score1_s, score2_s;
  logic        p1_ovl_s, p2_ovl_s;
  logic        sweep_start_s, sweep_step_s, sweep_done_s;
  logic [OW-1:0] x_off_s, y_off_s;

  logic [9:0]  x_r;
  logic [8:0]  y_r;
  logic [2:0]  color_r;
  logic        plot_r, busy_r, p1_point_r, p2_point_r;

  assign fb.X     = x_r;
  assign fb.Y     = y_r;
  assign fb.color = color_r;
  assign fb.plot  = plot_r;
  assign busy     = busy_r;
  assign p1_point = p1_point_r;
  assign p2_point = p2_point_r;

  // Vertical overlap of the ball with each paddle
  assign p1_ovl_s = (by_r + BS9 > p1_y) && (by_r < p1_y + PH9);
  assign p2_ovl_s = (by_r + BS9 > p2_y) && (by_r < p2_y + PH9);

  pixel_sweeper #(.SIZE(BALL_SIZE), .OW(OW)) u_sweeper (
    .clk   (clk),
    .rst   (rst),
    .start (sweep_start_s),
    .step  (sweep_step_s),
    .x_off (x_off_s),
    .y_off (y_off_s),
    .done  (sweep_done_s)
  );

  // FSM next state and sweeper control
  always_comb begin
    state_s       = state_r;
    sweep_start_s = 1'b0;
    sweep_step_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (tick) begin
          state_s       = ERASE;
          sweep_start_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      ERASE: begin
        sweep_step_s = 1'b1;
        if (sweep_done_s) state_s = MOVE;
        else              state_s = ERASE;
      end
      MOVE: begin
        sweep_start_s = 1'b1;
        state_s       = DRAW;
      end
      DRAW: begin
        sweep_step_s = 1'b1;
        if (sweep_done_s) state_s = IDLE;
        else              state_s = DRAW;
      end
      default: state_s = IDLE;
    endcase
  end

  // Ball motion: directions from the current position first, then one step;
  // a miss recentres without stepping and keeps the vertical direction
  always_comb begin
    ndx_s    = dir_x_r;
    ndy_s    = dir_y_r;
    nbx_s    = bx_r;
    nby_s    = by_r;
    score1_s = 1'b0;
    score2_s = 1'b0;
    if (!dir_y_r && (by_r + BS9 >= Y_LIM9)) ndy_s = 1'b1;
    else if (dir_y_r && (by_r <= WALL9))     ndy_s = 1'b0;
    else                                     ndy_s = dir_y_r;

    if (dir_x_r && (bx_r == 10'd0)) begin
      score2_s = 1'b1;
      nbx_s    = SX10;
      nby_s    = SY9;
      ndx_s    = 1'b0;
      ndy_s    = dir_y_r;
    end else if (!dir_x_r && (bx_r + BS10 == SCR_W10)) begin
      score1_s = 1'b1;
      nbx_s    = SX10;
      nby_s    = SY9;
      ndx_s    = 1'b1;
      ndy_s    = dir_y_r;
    end else begin
      if (dir_x_r && (bx_r == P1_EDGE) && p1_ovl_s)             ndx_s = 1'b0;
      else if (!dir_x_r && (bx_r + BS10 == P2_EDGE) && p2_ovl_s) ndx_s = 1'b1;
      else                                                        ndx_s = dir_x_r;
      nbx_s = ndx_s ? bx_r - 10'd1 : bx_r + 10'd1;
      nby_s = ndy_s ? by_r - 9'd1  : by_r + 9'd1;
    end
  end

  // State, ball position and registered framebuffer/status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      bx_r       <= SX10;
      by_r       <= SY9;
      dir_x_r    <= 1'b0;
      dir_y_r    <= 1'b0;
      x_r        <= 10'd0;
      y_r        <= 9'd0;
      color_r    <= 3'b000;
      plot_r     <= 1'b0;
      busy_r     <= 1'b0;
      p1_point_r <= 1'b0;
      p2_point_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      busy_r     <= (state_r != IDLE);
      p1_point_r <= 1'b0;
      p2_point_r <= 1'b0;
      case (state_r)
        ERASE: begin
          x_r     <= bx_r + 10'(x_off_s);
          y_r     <= by_r + 9'(y_off_s);
          color_r <= BLACK;
          plot_r  <= 1'b1;
        end
        DRAW: begin
          x_r     <= bx_r + 10'(x_off_s);
          y_r     <= by_r + 9'(y_off_s);
          color_r <= WHITE;
          plot_r  <= 1'b1;
        end
        MOVE: begin
          plot_r     <= 1'b0;
          bx_r       <= nbx_s;
          by_r       <= nby_s;
          dir_x_r    <= ndx_s;
          dir_y_r    <= ndy_s;
          p1_point_r <= score1_s;
          p2_point_r <= score2_s;
        end
        default: plot_r <= 1'b0;
      endcase
    end
  end

endmodule

// File: doc/ball_engine.md
BALL_ENGINE -- requirements
Module: ball_engine

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- BALL_SIZE, 4, ball edge in pixels
- PADDLE_H, 32, paddle height
- PADDLE_W, 4, paddle width
- P1_X, 8, left paddle left column
- P2_X, 308, right paddle left column
- WALL, 8, top/bottom wall thickness
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, sole clock
- rst, in, 1, synchronous active-high reset
- tick, in, 1, one-cycle frame-update pulse
- p1_y, in, 9, left paddle top row
- p2_y, in, 9, right paddle top row
- X, out, 10, framebuffer write column to vga_adapter
- Y, out, 9, framebuffer write row
- color, out, 3, write colour
- plot, out, 1, write enable
- busy, out, 1, update in progress
- p1_point, out, 1, one-cycle pulse when P1 scores
- p2_point, out, 1, one-cycle pulse when P2 scores
REQ-003 The design SHALL use one clock, clk, and a synchronous active-high reset, rst.
REQ-004 Screen geometry SHALL be fixed at 320x240 to match vga_adapter.

Function
REQ-005 FSM states SHALL be IDLE, ERASE, MOVE, DRAW. Transitions: IDLE->ERASE on tick; ERASE->MOVE after BALL_SIZE^2 pixels; MOVE->DRAW after 1 cycle; DRAW->IDLE after BALL_SIZE^2 pixels.
REQ-006 ERASE SHALL write colour 3'b000 and DRAW SHALL write colour 3'b111.
REQ-007 Each ERASE and DRAW pixel SHALL be emitted one per cycle with plot=1, in raster order (column fastest), covering (bx..bx+BALL_SIZE-1, by..by+BALL_SIZE-1).
REQ-008 For a tick sampled at edge 0, plot SHALL be high on cycles 1-16 (erase), low on cycle 17 (MOVE), high on cycles 18-33 (draw), and busy SHALL be high on cycles 1-33. These counts apply at BALL_SIZE=4.
REQ-009 A tick that arrives while busy=1 SHALL be ignored and not queued.
REQ-010 In MOVE, directions SHALL be updated from the current position first, then bx and by SHALL each step by 1 in the new direction. dir_x=1 means left; dir_y=1 means up.
REQ-011 Y bounce: if down and by+BALL_SIZE >= 240-WALL, set up; if up and by <= WALL, set down.
REQ-012 Left paddle bounce: if left, bx == P1_X+PADDLE_W, and by+BALL_SIZE > p1_y and by < p1_y+PADDLE_H, set right.
REQ-013 Right paddle bounce: if right, bx+BALL_SIZE == P2_X, and the same vertical overlap holds against p2_y, set left.
REQ-014 Miss: if left and bx == 0, pulse p2_point, set bx=158, by=118, and set dir_x right. If right and bx+BALL_SIZE == 320, pulse p1_point, recentre, and set dir_x left. No step SHALL occur on a miss tick.
REQ-015 X and Y bounces in the same MOVE SHALL both apply. A miss SHALL take precedence over an X bounce. dir_y SHALL be retained on a miss.
REQ-016 Paddle inputs SHALL be sampled only in the MOVE cycle.
REQ-017 All arithmetic SHALL be unsigned at 10 bits (X) and 9 bits (Y). Geometry SHALL keep the ball on-screen, so no wrap-around can occur.
REQ-018 Outputs SHALL be registered.

Reset
REQ-019 rst SHALL set the state to IDLE, bx=158, by=118, dir_x=0, dir_y=0, X=0, Y=0, color=0, plot=0, busy=0, and p1_point=p2_point=0 on the next edge.
REQ-020 rst mid-ERASE or mid-DRAW SHALL abort with plot=0 from the next cycle. Partially drawn pixels SHALL NOT be erased.

Structure
REQ-021 A shared package pong_pkg SHALL hold the screen size, WALL, the ball and paddle geometry, the colour constants (BLACK, WHITE), and the FSM state enum.
REQ-022 A sub-module pixel_sweeper SHALL implement the BALL_SIZE x BALL_SIZE 2-D counter, with start, x/y offsets, and a done pulse. It SHALL be instantiated once and shared by ERASE and DRAW.

Verification
REQ-023 After reset, tick once: expect 16 black writes at (158..161, 118..121), then 16 white writes at (159..162, 119..122). busy SHALL drop at cycle 34.
REQ-024 Preload by=WALL with dir_y up, tick: dir_y SHALL flip to down, and the draw SHALL be at row WALL+1.
REQ-025 Set bx=12, dir left, p1_y=100, by=110, tick: the ball SHALL bounce right and draw at bx=13. Repeat with p1_y=200: the ball SHALL continue left to bx=11.
REQ-026 Set bx=0, dir left, tick: p2_point SHALL pulse for exactly one cycle, and the draw SHALL be at (158,118) with dir right.
REQ-027 A tick issued at cycle 10 of an update SHALL produce no second update.
REQ-028 Assert rst at cycle 20 of an update: plot SHALL be 0 on the following cycle, and all state SHALL be at reset values.
